// File: rtl/deferred_check_pkg.sv
// Shared types for the deferred equality check queue.
// State enum, counter width/limit, record layout, saturating increment.
// Optional DEFERRED_CHECK_TIMESTAMP_EN adds a timestamp field to the record.
package deferred_check_pkg;

  typedef enum logic [1:0] {
    DC_IDLE,
    DC_PENDING,
    DC_FIRED
  } dc_state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam int REC_DW  = 8;
  localparam int REC_TSW = 16;

  typedef struct packed {
`ifdef DEFERRED_CHECK_TIMESTAMP_EN
    logic [REC_TSW-1:0] ts;
`endif
    logic [REC_DW-1:0]  a;
    logic [REC_DW-1:0]  b;
  } dc_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dc_fifo.sv
// Generic first-word-fall-through FIFO; push while full is honoured when a pop
// frees the slot in the same cycle. Ports: push_i/data_i, pop_i/data_o, full_o, empty_o.
module dc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop;
  logic         do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/deferred_check_queue.sv
// Deferred a/b equality check: mismatch must persist MATURE cycles to be
// queued as a record; shorter glitches are flushed and counted.
// Ports: clk, rst_n, en_i, a_i, b_i, rec_valid_o/rec_ready_i, rec_a_o, rec_b_o,
// rec_ts_o (DEFERRED_CHECK_TIMESTAMP_EN only), fail_cnt_o, flush_cnt_o, overflow_o.
module deferred_check_queue
  import deferred_check_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MATURE = 2,
  parameter int DEPTH  = 4,
  parameter int TS_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [WIDTH-1:0] rec_a_o,
  output logic [WIDTH-1:0] rec_b_o,
`ifdef DEFERRED_CHECK_TIMESTAMP_EN
  output logic [TS_W-1:0]  rec_ts_o,
`endif
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             overflow_o
);

`ifdef DEFERRED_CHECK_TIMESTAMP_EN
  localparam int RW = 2*WIDTH + TS_W;
`else
  localparam int RW = 2*WIDTH;
`endif

  dc_state_e        state_q, state_d;
  logic [3:0]       age_q, age_d;
  logic             mis;
  logic             mat;
  logic             flush;
  logic             mat_q;
  logic [RW-1:0]    cap_d, cap_q;
  logic [CNT_W-1:0] fail_q, flush_q;
  logic             ovf_q;
  logic             full;
  logic             empty;
  logic [RW-1:0]    head;

  assign mis = en_i && (a_i != b_i);

`ifdef DEFERRED_CHECK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign cap_d    = {ts_q, a_i, b_i};
  assign rec_ts_o = head[RW-1 -: TS_W];
`else
  assign cap_d = {a_i, b_i};
`endif

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    mat     = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      DC_IDLE: begin
        if (mis) begin
          age_d = 4'd1;
          if (MATURE == 1) begin
            mat     = 1'b1;
            state_d = DC_FIRED;
          end else begin
            state_d = DC_PENDING;
          end
        end
      end
      DC_PENDING: begin
        if (mis && (age_q + 4'd1 == 4'(MATURE))) begin
          mat     = 1'b1;
          state_d = DC_FIRED;
        end else if (mis) begin
          age_d = age_q + 4'd1;
        end else begin
          flush   = 1'b1;
          state_d = DC_IDLE;
        end
      end
      DC_FIRED: begin
        if (!mis) state_d = DC_IDLE;
      end
      default: state_d = DC_IDLE;
    endcase
  end

  // Maturity is registered; the captured record is pushed one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DC_IDLE;
      age_q   <= '0;
      mat_q   <= 1'b0;
      cap_q   <= '0;
      fail_q  <= '0;
      flush_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      mat_q   <= mat;
      if (mat)   cap_q   <= cap_d;
      if (mat)   fail_q  <= sat_inc(fail_q);
      if (flush) flush_q <= sat_inc(flush_q);
      if (mat_q && full && !rec_ready_i) ovf_q <= 1'b1;
    end
  end

  dc_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (mat_q),
    .data_i  (cap_q),
    .pop_i   (rec_ready_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rec_valid_o = !empty;
  assign rec_a_o     = head[2*WIDTH-1 -: WIDTH];
  assign rec_b_o     = head[WIDTH-1:0];
  assign fail_cnt_o  = fail_q;
  assign flush_cnt_o = flush_q;
  assign overflow_o  = ovf_q;

endmodule
